// File: rtl/crg_pkg.sv
// rtl/crg_pkg.sv - shared state encoding and counter sizing for the CRG reset sequencer
package crg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUALIFY,
        RELEASE,
        LOCKED
    } seq_state_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int safe_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/edge_activity_watchdog.sv
// rtl/edge_activity_watchdog.sv - counts edge-free cycles and flags loss of edge activity
module edge_activity_watchdog
    import crg_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk_ref,
    input  logic arst_ni,
    input  logic edge_in_ni,
    input  logic enable_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam int GW = safe_width(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

    logic [GW-1:0] gap_cnt;

    // Fires on the TIMEOUT-th consecutive cycle without an edge.
    assign timeout_o = enable_i && edge_in_ni && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk_ref or negedge arst_ni) begin
        if (!arst_ni) begin
            gap_cnt <= '0;
        end else if (clear_i || !enable_i || !edge_in_ni || (gap_cnt == GAP_LAST)) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/edge_rst_sequencer.sv
// rtl/edge_rst_sequencer.sv - qualifies edge activity, then releases staged active-low resets
module edge_rst_sequencer
    import crg_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int EDGE_COUNT  = 3,
    parameter int STAGE_DELAY = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic                  clk_ref,
    input  logic                  arst_ni,
    input  logic                  edge_in_ni,
    input  logic                  restart_i,
    output logic [NUM_STAGES-1:0] rst_no,
    output logic                  locked_o,
    output logic                  busy_o
);

    localparam int EW = safe_width(EDGE_COUNT + 1);
    localparam int DW = safe_width(STAGE_DELAY);
    localparam int SW = safe_width(NUM_STAGES + 1);
    localparam logic [EW-1:0] EDGE_LAST  = EW'(EDGE_COUNT - 1);
    localparam logic [DW-1:0] DLY_LAST   = DW'(STAGE_DELAY - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);

    seq_state_e    state;
    logic [EW-1:0] edge_cnt;
    logic [DW-1:0] dly_cnt;
    logic [SW-1:0] stage_idx;
    logic          edge_seen;
    logic          timeout;

    assign edge_seen = !edge_in_ni;

    edge_activity_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk_ref   (clk_ref),
        .arst_ni   (arst_ni),
        .edge_in_ni(edge_in_ni),
        .enable_i  (state != IDLE),
        .clear_i   (restart_i),
        .timeout_o (timeout)
    );

    always_ff @(posedge clk_ref or negedge arst_ni) begin
        if (!arst_ni) begin
            state     <= IDLE;
            edge_cnt  <= '0;
            dly_cnt   <= '0;
            stage_idx <= '0;
            rst_no    <= '0;
            locked_o  <= 1'b0;
            busy_o    <= 1'b0;
        end else if (restart_i) begin
            // Restart outranks edges, timeouts and pending releases.
            state     <= IDLE;
            edge_cnt  <= '0;
            dly_cnt   <= '0;
            stage_idx <= '0;
            rst_no    <= '0;
            locked_o  <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (edge_seen) begin
                        busy_o    <= 1'b1;
                        dly_cnt   <= '0;
                        stage_idx <= '0;
                        if (EDGE_COUNT == 1) begin
                            state    <= RELEASE;
                            edge_cnt <= '0;
                        end else begin
                            state    <= QUALIFY;
                            edge_cnt <= EW'(1);
                        end
                    end
                end
                QUALIFY: begin
                    if (timeout) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                        busy_o   <= 1'b0;
                    end else if (edge_seen) begin
                        if (edge_cnt == EDGE_LAST) begin
                            state     <= RELEASE;
                            edge_cnt  <= '0;
                            dly_cnt   <= '0;
                            stage_idx <= '0;
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (timeout) begin
                        state     <= IDLE;
                        dly_cnt   <= '0;
                        stage_idx <= '0;
                        rst_no    <= '0;
                        busy_o    <= 1'b0;
                    end else if (dly_cnt == DLY_LAST) begin
                        rst_no    <= rst_no | (STAGE_ONE << stage_idx);
                        dly_cnt   <= '0;
                        stage_idx <= stage_idx + 1'b1;
                        if (stage_idx == STAGE_LAST) begin
                            state    <= LOCKED;
                            locked_o <= 1'b1;
                            busy_o   <= 1'b0;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (timeout) begin
                        state     <= IDLE;
                        stage_idx <= '0;
                        rst_no    <= '0;
                        locked_o  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_rst_sequencer.sv
// tb/tb_edge_rst_sequencer.sv - directed self-checking bench for edge_rst_sequencer
module tb_edge_rst_sequencer;

    logic       clk_ref = 1'b0;
    logic       arst_n;
    logic       edge_n;
    logic       restart;
    logic [3:0] rst_n;
    logic       locked;
    logic       busy;

    logic       arst6_n;
    logic       edge6_n;
    logic       restart6;
    logic [1:0] rst6_n;
    logic       locked6;
    logic       busy6;

    int  n_checks = 0;
    int  n_errors = 0;
    int  phase    = 0;
    bit  auto_edge = 1'b0;

    always #5 clk_ref = ~clk_ref;

    edge_rst_sequencer dut (
        .clk_ref   (clk_ref),
        .arst_ni   (arst_n),
        .edge_in_ni(edge_n),
        .restart_i (restart),
        .rst_no    (rst_n),
        .locked_o  (locked),
        .busy_o    (busy)
    );

    edge_rst_sequencer #(
        .NUM_STAGES (2),
        .EDGE_COUNT (1),
        .STAGE_DELAY(1),
        .TIMEOUT    (64)
    ) dut6 (
        .clk_ref   (clk_ref),
        .arst_ni   (arst6_n),
        .edge_in_ni(edge6_n),
        .restart_i (restart6),
        .rst_no    (rst6_n),
        .locked_o  (locked6),
        .busy_o    (busy6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: edge driven when forced or when auto mode's 10-cycle period is due.
    task automatic step(input bit force_edge);
        edge_n = (force_edge || (auto_edge && phase >= 9)) ? 1'b0 : 1'b1;
        @(posedge clk_ref);
        #1;
        if (!edge_n) phase = 0;
        else phase++;
        edge_n = 1'b1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic seq_run(input string tag);
        auto_edge = 1'b1;
        phase = 9;
        step(1'b0);
        check({tag, " e1 busy"}, busy, 1);
        check({tag, " e1 rst"}, rst_n, 4'b0000);
        steps(10);
        check({tag, " e2 busy"}, busy, 1);
        steps(10);
        check({tag, " e3 busy"}, busy, 1);
        check({tag, " e3 rst"}, rst_n, 4'b0000);
        steps(15);
        check({tag, " +15 rst"}, rst_n, 4'b0000);
        step(1'b0);
        check({tag, " +16 rst"}, rst_n, 4'b0001);
        steps(15);
        check({tag, " +31 rst"}, rst_n, 4'b0001);
        step(1'b0);
        check({tag, " +32 rst"}, rst_n, 4'b0011);
        steps(16);
        check({tag, " +48 rst"}, rst_n, 4'b0111);
        check({tag, " +48 locked"}, locked, 0);
        steps(15);
        check({tag, " +63 rst"}, rst_n, 4'b0111);
        check({tag, " +63 busy"}, busy, 1);
        step(1'b0);
        check({tag, " +64 rst"}, rst_n, 4'b1111);
        check({tag, " +64 locked"}, locked, 1);
        check({tag, " +64 busy"}, busy, 0);
    endtask

    task automatic drop_lock(input string tag);
        auto_edge = 1'b0;
        step(1'b1);
        steps(63);
        check({tag, " gap63 rst"}, rst_n, 4'b1111);
        check({tag, " gap63 locked"}, locked, 1);
        step(1'b0);
        check({tag, " gap64 rst"}, rst_n, 4'b0000);
        check({tag, " gap64 locked"}, locked, 0);
        check({tag, " gap64 busy"}, busy, 0);
    endtask

    initial begin
        arst_n = 1'b0;
        edge_n = 1'b1;
        restart = 1'b0;
        arst6_n = 1'b0;
        edge6_n = 1'b1;
        restart6 = 1'b0;
        #2;
        check("reset rst", rst_n, 4'b0000);
        check("reset locked", locked, 0);
        check("reset busy", busy, 0);
        steps(2);
        arst_n = 1'b1;
        arst6_n = 1'b1;
        steps(3);
        check("idle rst", rst_n, 4'b0000);
        check("idle busy", busy, 0);

        seq_run("t1");
        drop_lock("t3a");
        seq_run("t3b");
        drop_lock("t3c");

        // Two edges then silence: qualification times out.
        step(1'b1);
        check("t2 e1 busy", busy, 1);
        steps(9);
        step(1'b1);
        steps(63);
        check("t2 gap63 busy", busy, 1);
        step(1'b0);
        check("t2 timeout busy", busy, 0);
        check("t2 timeout rst", rst_n, 4'b0000);
        step(1'b1);
        steps(9);
        step(1'b1);
        steps(20);
        check("t2 two edges rst", rst_n, 4'b0000);
        check("t2 two edges busy", busy, 1);
        steps(43);
        step(1'b0);
        check("t2 second timeout busy", busy, 0);

        // Restart mid-release, coincident edge discarded.
        auto_edge = 1'b1;
        phase = 9;
        steps(21);
        steps(32);
        check("t4 pre rst", rst_n, 4'b0011);
        auto_edge = 1'b0;
        restart = 1'b1;
        step(1'b1);
        restart = 1'b0;
        check("t4 restart rst", rst_n, 4'b0000);
        check("t4 restart busy", busy, 0);
        check("t4 restart locked", locked, 0);
        step(1'b1);
        check("t4 new e1 busy", busy, 1);
        steps(9);
        step(1'b1);
        steps(20);
        check("t4 edge not counted rst", rst_n, 4'b0000);
        steps(43);
        step(1'b0);
        check("t4 timeout busy", busy, 0);

        // Asynchronous reset mid-release.
        auto_edge = 1'b1;
        phase = 9;
        steps(21);
        steps(48);
        check("t5 pre rst", rst_n, 4'b0111);
        #2;
        arst_n = 1'b0;
        #1;
        check("t5 async rst", rst_n, 4'b0000);
        check("t5 async locked", locked, 0);
        check("t5 async busy", busy, 0);
        #1;
        arst_n = 1'b1;
        auto_edge = 1'b0;
        steps(20);
        check("t5 stays idle rst", rst_n, 4'b0000);
        check("t5 stays idle busy", busy, 0);

        // Minimal configuration: one edge, one-cycle stage spacing.
        check("t6 idle rst", rst6_n, 2'b00);
        edge6_n = 1'b0;
        @(posedge clk_ref);
        #1;
        edge6_n = 1'b1;
        check("t6 +0 rst", rst6_n, 2'b00);
        check("t6 +0 busy", busy6, 1);
        @(posedge clk_ref);
        #1;
        check("t6 +1 rst", rst6_n, 2'b01);
        check("t6 +1 locked", locked6, 0);
        @(posedge clk_ref);
        #1;
        check("t6 +2 rst", rst6_n, 2'b11);
        check("t6 +2 locked", locked6, 1);
        check("t6 +2 busy", busy6, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
